// File: rtl/lcd_nibble_receiver_if.sv
// Bus bundle for the LCD nibble receiver: the HD44780-style write bus from the host
// plus the decoded byte, display-RAM write and cursor outputs.
interface lcd_nibble_receiver_if;
    logic       D1;
    logic       D2;
    logic       D3;
    logic       D4;
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] byte_out;
    logic       byte_rs;
    logic       byte_valid;
    logic       ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_data;
    logic [6:0] cursor;
    logic       clear_pulse;
    logic       mode4;

    modport master (
        output D1, D2, D3, D4, rs, rw, en,
        input  byte_out, byte_rs, byte_valid, ram_we, ram_addr, ram_data,
               cursor, clear_pulse, mode4
    );

    modport slave (
        input  D1, D2, D3, D4, rs, rw, en,
        output byte_out, byte_rs, byte_valid, ram_we, ram_addr, ram_data,
               cursor, clear_pulse, mode4
    );
endinterface

// File: rtl/lcd_nibble_receiver.sv
// Snoops an HD44780 write bus: synchronizes it, reassembles bytes (8-bit init then
// 4-bit nibble pairs), tracks the DDRAM cursor and emits display-RAM write strobes.
module lcd_nibble_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clkout,
    input  logic                  reset,
    lcd_nibble_receiver_if.slave  bus
);
    typedef enum logic [1:0] {INIT8 = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [6:0] bus_raw;
    logic [6:0] bus_sync;
    logic       en_prev_reg;
    logic       en_s;
    logic       rw_s;
    logic       rs_s;
    logic [3:0] nib_s;
    logic       wr_fall;
    logic       emit;
    logic [7:0] emit_byte;
    logic       emit_rs;

    logic [3:0] upper_reg;
    logic       upper_rs_reg;
    logic [7:0] byte_out_reg;
    logic       byte_rs_reg;
    logic       byte_valid_reg;
    logic       ram_we_reg;
    logic [6:0] ram_addr_reg;
    logic [7:0] ram_data_reg;
    logic [6:0] cursor_reg;
    logic       clear_pulse_reg;
    logic       inc_dec_reg;

    assign bus_raw = {bus.en, bus.rw, bus.rs, bus.D4, bus.D3, bus.D2, bus.D1};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [6:0] q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clkout or negedge reset) begin
                    if (!reset) q <= '0;
                    else        q <= bus_raw;
                end
            end else begin : g_next
                always_ff @(posedge clkout or negedge reset) begin
                    if (!reset) q <= '0;
                    else        q <= g_sync[gi-1].q;
                end
            end
        end
    endgenerate

    assign bus_sync = g_sync[SYNC_STAGES-1].q;
    assign en_s     = bus_sync[6];
    assign rw_s     = bus_sync[5];
    assign rs_s     = bus_sync[4];
    assign nib_s    = bus_sync[3:0];

    // en_prev resets to 0, so an en already high at reset release never looks like a fall.
    always_ff @(posedge clkout or negedge reset) begin
        if (!reset) en_prev_reg <= 1'b0;
        else        en_prev_reg <= en_s;
    end

    assign wr_fall = en_prev_reg & ~en_s & ~rw_s;

    // FSM: state register
    always_ff @(posedge clkout or negedge reset) begin
        if (!reset) state_reg <= INIT8;
        else        state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (wr_fall) begin
            case (state_reg)
                INIT8:   if (!rs_s && nib_s == 4'h2) state_next = HIGH;
                HIGH:    state_next = LOW;
                LOW:     state_next = HIGH;
                default: state_next = INIT8;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        bus.mode4 = (state_reg != INIT8);
        emit      = wr_fall && (state_reg != HIGH);
        emit_byte = {upper_reg, nib_s};
        emit_rs   = upper_rs_reg;
        if (state_reg == INIT8) begin
            emit_byte = {nib_s, 4'h0};
            emit_rs   = rs_s;
        end
    end

    // Entry-mode stepping; addresses outside both visible lines just count plainly.
    function automatic logic [6:0] cursor_step(input logic [6:0] c, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (c == 7'h27)      r = 7'h40;
            else if (c == 7'h67) r = 7'h00;
            else                 r = c + 7'd1;
        end else begin
            if (c == 7'h00)      r = 7'h67;
            else if (c == 7'h40) r = 7'h27;
            else                 r = c - 7'd1;
        end
        return r;
    endfunction

    always_ff @(posedge clkout or negedge reset) begin
        if (!reset) begin
            upper_reg       <= '0;
            upper_rs_reg    <= 1'b0;
            byte_out_reg    <= '0;
            byte_rs_reg     <= 1'b0;
            byte_valid_reg  <= 1'b0;
            ram_we_reg      <= 1'b0;
            ram_addr_reg    <= '0;
            ram_data_reg    <= '0;
            clear_pulse_reg <= 1'b0;
        end else begin
            byte_valid_reg  <= emit;
            ram_we_reg      <= emit & emit_rs;
            clear_pulse_reg <= emit & ~emit_rs & (emit_byte == 8'h01);
            if (wr_fall && state_reg == HIGH) begin
                upper_reg    <= nib_s;
                upper_rs_reg <= rs_s;
            end
            if (emit) begin
                byte_out_reg <= emit_byte;
                byte_rs_reg  <= emit_rs;
                if (emit_rs) begin
                    ram_addr_reg <= cursor_reg;
                    ram_data_reg <= emit_byte;
                end
            end
        end
    end

    // Cursor and entry mode act on the emitted byte, one edge after byte_valid rises.
    always_ff @(posedge clkout or negedge reset) begin
        if (!reset) begin
            cursor_reg  <= '0;
            inc_dec_reg <= 1'b1;
        end else if (byte_valid_reg) begin
            if (byte_rs_reg) begin
                cursor_reg <= cursor_step(cursor_reg, inc_dec_reg);
            end else if (byte_out_reg[7]) begin
                cursor_reg <= byte_out_reg[6:0];
            end else if (byte_out_reg[6]) begin
                cursor_reg <= cursor_reg;
            end else if (byte_out_reg[7:2] == 6'b000001) begin
                inc_dec_reg <= byte_out_reg[1];
            end else if (byte_out_reg[7:1] == 7'b0000001) begin
                cursor_reg <= '0;
            end else if (byte_out_reg == 8'h01) begin
                cursor_reg  <= '0;
                inc_dec_reg <= 1'b1;
            end
        end
    end

    assign bus.byte_out    = byte_out_reg;
    assign bus.byte_rs     = byte_rs_reg;
    assign bus.byte_valid  = byte_valid_reg;
    assign bus.ram_we      = ram_we_reg;
    assign bus.ram_addr    = ram_addr_reg;
    assign bus.ram_data    = ram_data_reg;
    assign bus.cursor      = cursor_reg;
    assign bus.clear_pulse = clear_pulse_reg;
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Directed bench for lcd_nibble_receiver: init sequence, data writes, cursor wraps,
// clear, ignored reads and mid-byte reset, all against hand-computed values.
module tb_lcd_nibble_receiver;
    localparam int SYNC = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_valid;
    int   n_we;

    logic       seen;
    int         lat;
    logic [7:0] cap_byte;
    logic       cap_rs;
    logic       cap_we;
    logic [6:0] cap_addr;
    logic [7:0] cap_data;
    logic       cap_clr;

    lcd_nibble_receiver_if bus ();

    lcd_nibble_receiver #(.SYNC_STAGES(SYNC)) dut (
        .clkout (clk),
        .reset  (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.byte_valid) n_valid++;
        if (bus.ram_we)     n_we++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one en pulse and watches up to 8 cycles after the fall for byte_valid.
    task automatic pulse(input logic [3:0] nib, input logic rs_v, input logic rw_v);
        @(negedge clk);
        {bus.D4, bus.D3, bus.D2, bus.D1} = nib;
        bus.rs = rs_v;
        bus.rw = rw_v;
        bus.en = 1'b1;
        repeat (5) @(negedge clk);
        bus.en = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.byte_valid && !seen) begin
                seen     = 1'b1;
                lat      = i + 1;
                cap_byte = bus.byte_out;
                cap_rs   = bus.byte_rs;
                cap_we   = bus.ram_we;
                cap_addr = bus.ram_addr;
                cap_data = bus.ram_data;
                cap_clr  = bus.clear_pulse;
            end
        end
        $display("pulse nib=%h rs=%b rw=%b -> valid=%b byte=%h we=%b addr=%h cursor=%h mode4=%b",
                 nib, rs_v, rw_v, seen, cap_byte, cap_we, cap_addr, bus.cursor, bus.mode4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs_v);
        pulse(b[7:4], rs_v, 1'b0);
        chk("hi_nibble_no_valid", seen, 1'b0);
        pulse(b[3:0], rs_v, 1'b0);
        chk("byte_seen", seen, 1'b1);
        chk("byte_value", cap_byte, b);
        chk("byte_rs", cap_rs, rs_v);
        chk("latency", lat, SYNC + 1);
    endtask

    task automatic cmd_byte(input logic [7:0] b, input logic [6:0] exp_cursor);
        send_byte(b, 1'b0);
        chk("cmd_no_we", cap_we, 1'b0);
        chk("cmd_cursor", bus.cursor, exp_cursor);
    endtask

    task automatic data_byte(input logic [7:0] b, input logic [6:0] exp_addr,
                             input logic [6:0] exp_cursor);
        send_byte(b, 1'b1);
        chk("data_we", cap_we, 1'b1);
        chk("data_addr", cap_addr, exp_addr);
        chk("data_ram", cap_data, b);
        chk("data_cursor", bus.cursor, exp_cursor);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_out"}, bus.byte_out, 8'h00);
        chk({tag, "_byte_rs"}, bus.byte_rs, 1'b0);
        chk({tag, "_valid"}, bus.byte_valid, 1'b0);
        chk({tag, "_we"}, bus.ram_we, 1'b0);
        chk({tag, "_addr"}, bus.ram_addr, 7'h00);
        chk({tag, "_data"}, bus.ram_data, 8'h00);
        chk({tag, "_cursor"}, bus.cursor, 7'h00);
        chk({tag, "_clear"}, bus.clear_pulse, 1'b0);
        chk({tag, "_mode4"}, bus.mode4, 1'b0);
    endtask

    initial begin
        int v0;
        int we0;
        logic [7:0] init_nib [4];
        n_checks = 0;
        n_errors = 0;
        n_valid  = 0;
        n_we     = 0;
        seen     = 1'b0;
        lat      = 0;
        cap_byte = '0; cap_rs = 1'b0; cap_we = 1'b0;
        cap_addr = '0; cap_data = '0; cap_clr = 1'b0;
        init_nib[0] = 8'h3; init_nib[1] = 8'h3; init_nib[2] = 8'h3; init_nib[3] = 8'h2;

        // en and rw held high through reset release
        rst_n  = 1'b0;
        bus.D1 = 1'b0; bus.D2 = 1'b0; bus.D3 = 1'b0; bus.D4 = 1'b0;
        bus.rs = 1'b0; bus.rw = 1'b1; bus.en = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_false_fall", n_valid, 0);
        bus.en = 1'b0;
        repeat (6) @(negedge clk);
        chk("read_fall_ignored", n_valid, 0);
        chk("read_fall_mode4", bus.mode4, 1'b0);

        // 8-bit init: 3,3,3,2
        for (int i = 0; i < 4; i++) begin
            pulse(init_nib[i][3:0], 1'b0, 1'b0);
            chk("init_seen", seen, 1'b1);
            chk("init_byte", cap_byte, {init_nib[i][3:0], 4'h0});
            chk("init_latency", lat, SYNC + 1);
            chk("init_mode4", bus.mode4, (i == 3));
        end
        chk("init_valid_count", n_valid, 4);
        chk("init_no_we", n_we, 0);

        data_byte(8'h41, 7'h00, 7'h01);
        cmd_byte(8'hA7, 7'h27);
        data_byte(8'h58, 7'h27, 7'h40);
        cmd_byte(8'h04, 7'h40);
        data_byte(8'h61, 7'h40, 7'h27);
        data_byte(8'h62, 7'h27, 7'h26);
        cmd_byte(8'h80, 7'h00);
        data_byte(8'h63, 7'h00, 7'h67);
        cmd_byte(8'h06, 7'h67);
        data_byte(8'h64, 7'h67, 7'h00);
        cmd_byte(8'hFF, 7'h7F);
        data_byte(8'h65, 7'h7F, 7'h00);
        cmd_byte(8'h04, 7'h00);
        cmd_byte(8'hC5, 7'h45);
        cmd_byte(8'h01, 7'h00);
        chk("clear_pulse", cap_clr, 1'b1);
        data_byte(8'h66, 7'h00, 7'h01);
        cmd_byte(8'h90, 7'h10);
        cmd_byte(8'h42, 7'h10);
        chk("cgram_no_clear", cap_clr, 1'b0);
        cmd_byte(8'h02, 7'h00);

        // rs changes between nibbles: latched rs wins
        pulse(4'h5, 1'b1, 1'b0);
        pulse(4'hA, 1'b0, 1'b0);
        chk("rs_mix_byte", cap_byte, 8'h5A);
        chk("rs_mix_rs", cap_rs, 1'b1);
        chk("rs_mix_we", cap_we, 1'b1);
        chk("rs_mix_cursor", bus.cursor, 7'h01);

        // read pulses between nibbles
        v0  = n_valid;
        we0 = n_we;
        pulse(4'h4, 1'b1, 1'b0);
        pulse(4'hF, 1'b0, 1'b1);
        chk("read1_no_valid", seen, 1'b0);
        pulse(4'h0, 1'b1, 1'b1);
        chk("read2_no_valid", seen, 1'b0);
        pulse(4'h8, 1'b1, 1'b0);
        chk("read_mix_byte", cap_byte, 8'h48);
        chk("read_mix_addr", cap_addr, 7'h01);
        chk("read_mix_valid_count", n_valid - v0, 1);
        chk("read_mix_we_count", n_we - we0, 1);

        // reset between high and low nibble
        pulse(4'h3, 1'b0, 1'b0);
        chk("mid_hi_no_valid", seen, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        pulse(4'h3, 1'b0, 1'b0);
        chk("post_reset_seen", seen, 1'b1);
        chk("post_reset_byte", cap_byte, 8'h30);
        chk("post_reset_mode4", bus.mode4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lcd_nibble_receiver.md
LCD_NIBBLE_RECEIVER -- requirements
Module: lcd_nibble_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on D1..D4, rs, rw and en (legal range 2-4).
REQ-002 SHALL have port clkout, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports D1, D2, D3 and D4, each input, 1 bit: LCD data nibble, with D4 as bit 3 and D1 as bit 0.
REQ-005 SHALL have port rs, input, 1 bit: 0 = command, 1 = character data.
REQ-006 SHALL have port rw, input, 1 bit: 0 = write, 1 = read.
REQ-007 SHALL have port en, input, 1 bit: LCD strobe; data is latched on its falling edge.
REQ-008 SHALL have port byte_out, output, 8 bits: last assembled byte.
REQ-009 SHALL have port byte_rs, output, 1 bit: rs value that belongs to byte_out.
REQ-010 SHALL have port byte_valid, output, 1 bit: 1-cycle pulse when a byte completes.
REQ-011 SHALL have port ram_we, output, 1 bit: 1-cycle display-RAM write strobe.
REQ-012 SHALL have port ram_addr, output, 7 bits: display-RAM write address.
REQ-013 SHALL have port ram_data, output, 8 bits: display-RAM write data.
REQ-014 SHALL have port cursor, output, 7 bits: current DDRAM address counter.
REQ-015 SHALL have port clear_pulse, output, 1 bit: 1-cycle pulse on a Clear Display command.
REQ-016 SHALL have port mode4, output, 1 bit: 1 once the 4-bit interface is active.

Function
REQ-017 SHALL pass all bus inputs through SYNC_STAGES flops and detect a falling edge of en as synchronized en = 0 while its previous value was 1.
REQ-018 SHALL require the bus driver to hold D1..D4, rs and rw stable for at least SYNC_STAGES+1 clkout cycles around the en fall; the block then samples them on the same cycle as the en fall.
REQ-019 SHALL ignore every en fall that has rw = 1; such a fall does not change state, phase or outputs.
REQ-020 SHALL use states INIT8, HIGH and LOW, entering INIT8 at reset.
REQ-021 INIT8: each write fall SHALL be treated as a complete byte {nibble, 4'h0}; a command nibble 4'h2 (rs = 0) SHALL move the block to HIGH and set mode4 = 1. Every other nibble keeps the state INIT8.
REQ-022 HIGH: a write fall SHALL latch the nibble as the upper nibble and latch rs, then move to LOW.
REQ-023 LOW: a write fall SHALL form the byte as {upper nibble, nibble}, emit it, and move to HIGH.
REQ-024 LOW: if rs at the second nibble differs from the latched rs, the block SHALL still emit the byte with the latched rs.
REQ-025 Byte emit: byte_out and byte_rs SHALL update and byte_valid SHALL pulse high for exactly one cycle, one cycle after the edge-detect cycle.
REQ-026 The total latency from the first rising edge that samples en = 0 to byte_valid high SHALL be SYNC_STAGES+1 edges.
REQ-027 Command decode (byte_rs = 0) SHALL act on the emitted byte, using priority from the MSB down:
- 1xxxxxxx: cursor = byte[6:0].
- 01xxxxxx: CGRAM address; ignored.
- 000001xx: inc_dec = byte[1].
- 0000001x: cursor = 0.
- 00000001: cursor = 0, inc_dec = 1, clear_pulse in the same cycle as byte_valid.
- all other commands: no effect.
REQ-028 Data (byte_rs = 1): ram_we SHALL pulse high with ram_addr = cursor (pre-update) and ram_data = byte in the same cycle as byte_valid; cursor then advances on the next edge.
REQ-029 Increment (inc_dec = 1) SHALL step cursor +1, with the following wraps:
- 0x27 -> 0x40.
- 0x67 -> 0x00.
REQ-030 Decrement (inc_dec = 0) SHALL step cursor -1, with the following wraps:
- 0x00 -> 0x67.
- 0x40 -> 0x27.
REQ-031 A Set-DDRAM command addressing 0x28-0x3F or 0x68-0x7F SHALL load cursor as given; the next increment from such a value SHALL be a plain +1, and the value 0x7F SHALL wrap to 0x00.
REQ-032 In INIT8, data bytes SHALL write to RAM and commands SHALL decode exactly as in 4-bit mode.

Reset
REQ-033 On reset = 0, the block SHALL immediately and asynchronously set: state INIT8, mode4 = 0, byte_out = 0, byte_rs = 0, byte_valid = 0, ram_we = 0, ram_addr = 0, ram_data = 0, cursor = 0, clear_pulse = 0, inc_dec = 1, all synchronizer flops = 0.
REQ-034 Because the synchronizers reset to 0, an en held at 1 across reset release SHALL NOT create a false fall.
REQ-035 Reset asserted while in LOW SHALL discard the latched upper nibble.

Verification
REQ-036 Init sequence: nibbles 3, 3, 3, 2 (rs = 0) -> mode4 = 1 after the 4th fall; 4 byte_valid pulses with byte_out 0x30, 0x30, 0x30, 0x20.
REQ-037 After init, data 0x41 as nibbles 4, 1 (rs = 1) -> byte_out = 0x41, byte_rs = 1, ram_we with addr 0x00 and data 0x41, then cursor = 0x01; byte_valid arrives SYNC_STAGES+1 edges after en is sampled low.
REQ-038 Address wrap: command 0xA7 (cursor = 0x27), then data 0x58 -> write at 0x27, cursor = 0x40; then command 0x04 and two data bytes -> writes at 0x40 and 0x27.
REQ-039 Clear: command 0x01 -> clear_pulse and byte_valid in the same cycle, cursor = 0x00, inc_dec = 1.
REQ-040 Reads ignored: rw = 1 en pulses interleaved between a high and a low nibble -> exactly one byte with the correct value; the read pulses cause no ram_we.
REQ-041 Mid-byte reset: after the high nibble, reset is pulsed low for 1 cycle -> all outputs return to their reset values, mode4 = 0, and the next nibble 3 is treated as INIT8 byte 0x30.
